// File: rtl/perceptron_vote_display.sv
// Windowed majority vote over the perceptron's 1-bit classification stream.
// Reports each completed window as a decision pulse and a 7-segment hex count.
module perceptron_vote_display #(
  parameter int WINDOW = 8,
  parameter int THRESH = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic       class_in,
  input  logic       clear,
  output logic [3:0] ones_count,
  output logic       decision,
  output logic       decision_valid,
  output logic [6:0] seg
);

  localparam logic [3:0] WIN_LAST = 4'(WINDOW - 1);
  localparam logic [3:0] THRESH_C = 4'(THRESH);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    REPORT  = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] sample_cnt_r;
  logic [3:0] sample_cnt_nxt_s;
  logic [3:0] ones_nxt_s;
  logic [3:0] ones_total_s;
  logic       report_s;

  // Hex digit to {g,f,e,d,c,b,a} active-high segments.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] segs;
    case (digit)
      4'h0:    segs = 7'h3F;
      4'h1:    segs = 7'h06;
      4'h2:    segs = 7'h5B;
      4'h3:    segs = 7'h4F;
      4'h4:    segs = 7'h66;
      4'h5:    segs = 7'h6D;
      4'h6:    segs = 7'h7D;
      4'h7:    segs = 7'h07;
      4'h8:    segs = 7'h7F;
      4'h9:    segs = 7'h6F;
      4'hA:    segs = 7'h77;
      4'hB:    segs = 7'h7C;
      4'hC:    segs = 7'h39;
      4'hD:    segs = 7'h5E;
      4'hE:    segs = 7'h79;
      4'hF:    segs = 7'h71;
      default: segs = 7'h00;
    endcase
    return segs;
  endfunction

  // Sample acceptance and window bookkeeping; the REPORT cycle accepts samples
  // like COLLECT, so back-to-back windows lose nothing.
  always_comb begin
    sample_cnt_nxt_s = sample_cnt_r;
    ones_nxt_s       = ones_count;
    report_s         = 1'b0;
    ones_total_s     = ones_count + {3'b000, class_in};
    if (clear) begin
      sample_cnt_nxt_s = 4'd0;
      ones_nxt_s       = 4'd0;
    end else if (sample_en) begin
      if (sample_cnt_r == WIN_LAST) begin
        report_s         = 1'b1;
        sample_cnt_nxt_s = 4'd0;
        ones_nxt_s       = 4'd0;
      end else begin
        sample_cnt_nxt_s = sample_cnt_r + 4'd1;
        ones_nxt_s       = ones_total_s;
      end
    end else begin
      sample_cnt_nxt_s = sample_cnt_r;
      ones_nxt_s       = ones_count;
    end
  end

  // Next-state selection; REPORT always lasts a single cycle.
  always_comb begin
    state_nxt_s = COLLECT;
    case (state_r)
      COLLECT: begin
        if (report_s) begin
          state_nxt_s = REPORT;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      REPORT:  state_nxt_s = COLLECT;
      default: state_nxt_s = COLLECT;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= COLLECT;
      sample_cnt_r   <= 4'd0;
      ones_count     <= 4'd0;
      decision       <= 1'b0;
      decision_valid <= 1'b0;
      seg            <= 7'h00;
    end else begin
      state_r        <= state_nxt_s;
      sample_cnt_r   <= sample_cnt_nxt_s;
      ones_count     <= ones_nxt_s;
      decision_valid <= report_s;
      if (report_s) begin
        decision <= (ones_total_s >= THRESH_C);
        seg      <= seg_encode(ones_total_s);
      end
    end
  end

endmodule

// File: tb/tb_perceptron_vote_display.sv
// Directed bench for perceptron_vote_display with default WINDOW=8, THRESH=5.
module tb_perceptron_vote_display;

  logic       clk;
  logic       rst;
  logic       sample_en;
  logic       class_in;
  logic       clear;
  logic [3:0] ones_count;
  logic       decision;
  logic       decision_valid;
  logic [6:0] seg;

  int total;
  int bad;

  perceptron_vote_display dut (
    .clk            (clk),
    .rst            (rst),
    .sample_en      (sample_en),
    .class_in       (class_in),
    .clear          (clear),
    .ones_count     (ones_count),
    .decision       (decision),
    .decision_valid (decision_valid),
    .seg            (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic en, input logic cls, input logic clr);
    sample_en = en;
    class_in  = cls;
    clear     = clr;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    class_in  = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sample_en = 1'b0; class_in = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (seg !== 7'h00) begin bad++; $display("FAIL reset_seg got=%h exp=00", seg); end
    total++; if (decision !== 1'b0) begin bad++; $display("FAIL reset_decision got=%b exp=0", decision); end
    total++; if (decision_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", decision_valid); end
    total++; if (ones_count !== 4'd0) begin bad++; $display("FAIL reset_ones got=%0d exp=0", ones_count); end
  endtask

  task automatic test_basic();
    logic [7:0] pat;
    logic [3:0] exp_ones;
    pat = 8'b00011111;
    exp_ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, pat[i], 1'b0);
      if (i < 7) begin
        exp_ones = exp_ones + {3'b000, pat[i]};
        total++; if (ones_count !== exp_ones) begin bad++; $display("FAIL basic_ones i=%0d got=%0d exp=%0d", i, ones_count, exp_ones); end
        total++; if (decision_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid i=%0d got=%b exp=0", i, decision_valid); end
      end
    end
    total++; if (decision_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", decision_valid); end
    total++; if (decision !== 1'b1) begin bad++; $display("FAIL basic_decision got=%b exp=1", decision); end
    total++; if (seg !== 7'h6D) begin bad++; $display("FAIL basic_seg got=%h exp=6d", seg); end
    total++; if (ones_count !== 4'd0) begin bad++; $display("FAIL basic_ones_restart got=%0d exp=0", ones_count); end
    tick(1'b0, 1'b0, 1'b0);
    total++; if (decision_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%b exp=0", decision_valid); end
    total++; if (seg !== 7'h6D) begin bad++; $display("FAIL basic_seg_hold got=%h exp=6d", seg); end
    total++; if (decision !== 1'b1) begin bad++; $display("FAIL basic_decision_hold got=%b exp=1", decision); end
  endtask

  task automatic test_gaps();
    logic [3:0] exp_ones;
    logic       cls;
    exp_ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cls = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick(1'b1, cls, 1'b0);
      if (i < 7) begin
        exp_ones = exp_ones + {3'b000, cls};
        total++; if (ones_count !== exp_ones) begin bad++; $display("FAIL gaps_ones i=%0d got=%0d exp=%0d", i, ones_count, exp_ones); end
        for (int g = 0; g < (i % 4); g++) begin
          tick(1'b0, 1'b1, 1'b0);
          total++; if (ones_count !== exp_ones) begin bad++; $display("FAIL gaps_idle_ones i=%0d got=%0d exp=%0d", i, ones_count, exp_ones); end
          total++; if (decision_valid !== 1'b0) begin bad++; $display("FAIL gaps_idle_valid i=%0d got=%b exp=0", i, decision_valid); end
        end
      end
    end
    total++; if (decision_valid !== 1'b1) begin bad++; $display("FAIL gaps_valid got=%b exp=1", decision_valid); end
    total++; if (decision !== 1'b0) begin bad++; $display("FAIL gaps_decision got=%b exp=0", decision); end
    total++; if (seg !== 7'h66) begin bad++; $display("FAIL gaps_seg got=%h exp=66", seg); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (i == 7 || i == 15) begin
        total++; if (decision_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid i=%0d got=%b exp=1", i, decision_valid); end
        total++; if (decision !== 1'b1) begin bad++; $display("FAIL b2b_decision i=%0d got=%b exp=1", i, decision); end
        total++; if (seg !== 7'h7F) begin bad++; $display("FAIL b2b_seg i=%0d got=%h exp=7f", i, seg); end
      end else begin
        total++; if (decision_valid !== 1'b0) begin bad++; $display("FAIL b2b_novalid i=%0d got=%b exp=0", i, decision_valid); end
        total++; if (ones_count !== 4'((i % 8) + 1)) begin bad++; $display("FAIL b2b_ones i=%0d got=%0d exp=%0d", i, ones_count, (i % 8) + 1); end
      end
    end
    tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
    total++; if (ones_count !== 4'd3) begin bad++; $display("FAIL clear_pre_ones got=%0d exp=3", ones_count); end
    tick(1'b1, 1'b1, 1'b1);
    total++; if (ones_count !== 4'd0) begin bad++; $display("FAIL clear_ones got=%0d exp=0", ones_count); end
    total++; if (seg !== 7'h7F) begin bad++; $display("FAIL clear_seg_hold got=%h exp=7f", seg); end
    // Two ones then six zeros: a full fresh window of 8 is needed.
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, (i < 2) ? 1'b1 : 1'b0, 1'b0);
      if (i < 7) begin
        total++; if (decision_valid !== 1'b0) begin bad++; $display("FAIL clear_early_valid i=%0d got=%b exp=0", i, decision_valid); end
      end
    end
    total++; if (decision_valid !== 1'b1) begin bad++; $display("FAIL clear_valid got=%b exp=1", decision_valid); end
    total++; if (decision !== 1'b0) begin bad++; $display("FAIL clear_decision got=%b exp=0", decision); end
    total++; if (seg !== 7'h5B) begin bad++; $display("FAIL clear_seg got=%h exp=5b", seg); end
    // Clear during the REPORT cycle drops that cycle's sample.
    tick(1'b1, 1'b1, 1'b1);
    total++; if (ones_count !== 4'd0) begin bad++; $display("FAIL clear_report_ones got=%0d exp=0", ones_count); end
    total++; if (decision_valid !== 1'b0) begin bad++; $display("FAIL clear_report_valid got=%b exp=0", decision_valid); end
    total++; if (seg !== 7'h5B) begin bad++; $display("FAIL clear_report_seg got=%h exp=5b", seg); end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b0);
    total++; if (ones_count !== 4'd6) begin bad++; $display("FAIL rstmid_pre_ones got=%0d exp=6", ones_count); end
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    total++; if (ones_count !== 4'd0) begin bad++; $display("FAIL rstmid_ones got=%0d exp=0", ones_count); end
    total++; if (seg !== 7'h00) begin bad++; $display("FAIL rstmid_seg got=%h exp=00", seg); end
    total++; if (decision !== 1'b0) begin bad++; $display("FAIL rstmid_decision got=%b exp=0", decision); end
    total++; if (decision_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", decision_valid); end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (i < 7) begin
        total++; if (decision_valid !== 1'b0) begin bad++; $display("FAIL rstmid_early_valid i=%0d got=%b exp=0", i, decision_valid); end
      end
    end
    total++; if (decision_valid !== 1'b1) begin bad++; $display("FAIL rstmid_valid_after got=%b exp=1", decision_valid); end
    total++; if (seg !== 7'h7F) begin bad++; $display("FAIL rstmid_seg_after got=%h exp=7f", seg); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_clear();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
